gray_capture_controller: RTL
============================

// Module: gray_capture_controller
// PURPOSE
//  Sequences the Gray-code input path: synchronises and debounces the 4 switches,
//  commits a new stable Gray word, converts it to binary bit-serially, then hands
//  it to the LED/7-segment consumers over a valid/ready handshake.
//  Sits between the board switches and the LED driver / 7-segment display driver.
//  The LED and display drivers see only committed, glitch-free binary values.
// PARAMETERS
//  WIDTH            4          Gray/binary word width (>=2)
//  DEBOUNCE_CYCLES  1_000_000  consecutive stable cycles required (10 ms @ 100 MHz); >=2
//  CNT_W            8          width of change_count
// PORTS
//  clk           in   1        100 MHz system clock
//  reset         in   1        synchronous, active-high
//  sw_gray       in   WIDTH    raw asynchronous switch inputs, Gray code
//  out_bin       out  WIDTH    converted binary value; stable while out_valid=1
//  out_valid     out  1        out_bin holds a new committed value
//  out_ready     in   1        consumer accepts out_bin when out_valid & out_ready
//  busy          out  1        state != IDLE
//  change_count  out  CNT_W    number of accepted transfers, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE; sync flops, cand, committed, out_bin=0;
//    out_valid=0; change_count=0; busy=0. Reset wins over every other event,
//    including mid-SETTLE/CONVERT/PUBLISH; any in-flight value is discarded.
//  - Synchroniser: 2 flops on sw_gray -> sw_sync; no other logic sees sw_gray.
//  - FSM: IDLE, SETTLE, CONVERT, PUBLISH.
//    IDLE: if sw_sync != committed -> SETTLE, cand<=sw_sync, cnt<=0.
//    SETTLE: if sw_sync != cand -> cand<=sw_sync, cnt<=0 (restart).
//      else if cnt==DEBOUNCE_CYCLES-1: cand==committed -> IDLE (bounce back, no
//      publish); else -> CONVERT, committed<=cand, idx<=WIDTH-1.
//      else cnt<=cnt+1.
//    CONVERT: one bit per cycle, MSB first: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
//      After idx==0 -> PUBLISH with out_valid<=1 (registered).
//    PUBLISH: out_bin/out_valid held; sw_sync ignored. On out_valid&out_ready:
//      out_valid<=0, change_count<=change_count+1, -> IDLE.
//  - out_bin updates only on the CONVERT->PUBLISH transition; it keeps the last
//    published value in IDLE/SETTLE/CONVERT (consumers may sample it anytime).
//  - Latency: sw_sync changes at cycle N, stays stable -> out_valid=1 at cycle
//    N+1+DEBOUNCE_CYCLES+WIDTH. out_ready already high -> transfer that cycle,
//    out_valid=0 next cycle; IDLE can re-trigger the cycle after that.
//  - Switch change during PUBLISH is detected in IDLE after the handshake.
//  - cnt width = clog2(DEBOUNCE_CYCLES); no overflow possible.
//  - change_count wraps 2^CNT_W-1 -> 0 silently.
// STRUCTURE
//  - Shared package gray_pkg: FSM state encodings (IDLE=0,SETTLE=1,CONVERT=2,
//    PUBLISH=3), default WIDTH, CLK_HZ=100_000_000, DEBOUNCE_MS=10.
//  - One sub-module: gray_sync_debounce (2-flop sync + cand/cnt stability
//    counter, outputs sw_sync, stable pulse, cand). FSM + converter stay here.
// TESTING (bench uses DEBOUNCE_CYCLES=4, WIDTH=4, out_ready=1 unless stated)
//  1 Reset held 3 cycles, sw_gray=0 -> out_bin=0, out_valid=0, busy=0, count=0.
//  2 sw_gray 0000->0110 stable -> out_valid=1 at N+9 with out_bin=0100; count=1.
//  3 sw_gray=1000 with 1-cycle glitches every 3 cycles, then stable -> single
//    publish, out_bin=1111; no publish during bouncing.
//  4 committed 0110, sw pulses to 0111 for 2 cycles then back -> return to IDLE,
//    no out_valid, count unchanged.
//  5 out_ready=0 for 20 cycles in PUBLISH, sw changes to 0001 meanwhile ->
//    out_bin stays 0100; after ready, second publish out_bin=0001.
//  6 Reset asserted during CONVERT -> next cycle state IDLE, out_valid=0,
//    out_bin=0; 256 transfers -> change_count wraps to 0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code capture path.
//  - gray_state_e : controller FSM encoding (IDLE=0, SETTLE=1, CONVERT=2, PUBLISH=3)
//  - DEFAULT_WIDTH, CLK_HZ, DEBOUNCE_MS and the derived default debounce length.
package gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_PUBLISH = 2'd3
  } gray_state_e;

  localparam int DEFAULT_WIDTH           = 4;
  localparam int CLK_HZ                  = 100_000_000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/gray_sync_debounce.sv
// Two-flop synchroniser plus candidate/stability counter.
// Ports:
//  clk, reset  : system clock, synchronous active-high reset
//  sw_gray     : raw asynchronous switch inputs
//  restart     : load cand from sw_sync and clear the counter
//  active      : counting enabled (controller is settling)
//  sw_sync     : synchronised switch word
//  cand        : candidate word being checked for stability
//  stable      : cand has been seen for DEBOUNCE_CYCLES consecutive cycles
module gray_sync_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_gray,
  input  logic             restart,
  input  logic             active,
  output logic [WIDTH-1:0] sw_sync,
  output logic [WIDTH-1:0] cand,
  output logic             stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [CW-1:0]    cnt;

  // Any change of the synchronised word while active restarts the window,
  // so stable only fires after an uninterrupted run of DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sw_sync <= '0;
      cand    <= '0;
      cnt     <= '0;
    end else begin
      sync1   <= sw_gray;
      sw_sync <= sync1;
      if (restart || (active && (sw_sync != cand))) begin
        cand <= sw_sync;
        cnt  <= '0;
      end else if (active && (cnt != LAST)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign stable = active && (sw_sync == cand) && (cnt == LAST);

endmodule

// File: rtl/gray_capture_controller.sv
// Gray-code capture controller: synchronises and debounces the switches,
// commits a new stable Gray word, converts it to binary one bit per cycle
// (MSB first) and offers it to the LED / 7-segment consumers.
// Ports:
//  clk, reset    : system clock, synchronous active-high reset
//  sw_gray       : raw asynchronous Gray-coded switches
//  out_bin       : last published binary value (changes only on publish)
//  out_valid     : out_bin holds a new committed value
//  out_ready     : consumer accepts
//  busy          : controller is not idle
//  change_count  : accepted transfers, wraps modulo 2^CNT_W
//  dbg_state     : current FSM state
//
// Handshake: a transfer happens on a rising clk edge where out_valid and
// out_ready are both high. Once raised, out_valid stays high and out_bin stays
// constant until that transfer; out_valid does not depend on out_ready.
module gray_capture_controller
  import gray_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_gray,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] change_count,
  output gray_state_e      dbg_state
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  gray_state_e      state_q, state_d;
  logic [WIDTH-1:0] sw_sync, cand, committed;
  logic             stable, restart, active;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] conv, conv_d;
  logic             prev_bit, conv_bit;

  assign restart = (state_q == ST_IDLE) && (sw_sync != committed);
  assign active  = (state_q == ST_SETTLE);

  gray_sync_debounce #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk     (clk),
    .reset   (reset),
    .sw_gray (sw_gray),
    .restart (restart),
    .active  (active),
    .sw_sync (sw_sync),
    .cand    (cand),
    .stable  (stable)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (sw_sync != committed) state_d = ST_SETTLE;
      // A run that settles back on the committed word was only a bounce.
      ST_SETTLE:  if (stable) state_d = (cand == committed) ? ST_IDLE : ST_CONVERT;
      ST_CONVERT: if (idx == '0) state_d = ST_PUBLISH;
      ST_PUBLISH: if (out_valid && out_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Serial Gray->binary: b[i] = b[i+1] ^ g[i]; prev_bit carries b[i+1]
  // and starts at 0 so the MSB passes straight through.
  always_comb begin
    conv_bit    = prev_bit ^ committed[idx];
    conv_d      = conv;
    conv_d[idx] = conv_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      committed    <= '0;
      idx          <= '0;
      conv         <= '0;
      prev_bit     <= 1'b0;
      out_bin      <= '0;
      out_valid    <= 1'b0;
      change_count <= '0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (stable && (cand != committed)) begin
            committed <= cand;
            idx       <= IDX_MSB;
            prev_bit  <= 1'b0;
          end
        end
        ST_CONVERT: begin
          conv     <= conv_d;
          prev_bit <= conv_bit;
          idx      <= idx - IW'(1);
          if (idx == '0) begin
            out_bin   <= conv_d;
            out_valid <= 1'b1;
          end
        end
        ST_PUBLISH: begin
          if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
            change_count <= change_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
